// File: rtl/inst_fetch_if.sv
// Handshake and ROM bus bundle between the instruction fetch stage, its
// instruction ROM and the downstream decode stage.
interface inst_fetch_if;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;

  modport master (
    input  stall_i, branch_i, branch_target_i, flush_i, new_pc_i, rom_inst_i,
    output rom_ce_o, rom_addr_o, if_valid_o, if_pc_o, if_inst_o
  );

  modport slave (
    output stall_i, branch_i, branch_target_i, flush_i, new_pc_i, rom_inst_i,
    input  rom_ce_o, rom_addr_o, if_valid_o, if_pc_o, if_inst_o
  );
endinterface

// File: rtl/inst_fetch.sv
// Single-issue instruction fetch stage with a 1-cycle registered ROM.
// Optional FETCH_SKID_EN: capture the stalled word locally instead of relying on ROM hold.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        fetch_ce;
  logic        hold_pres;
  logic [31:0] inst_src;

  always_comb begin
    fetch_ce  = (state_q == RUN) & ~bus.stall_i & ~bus.flush_i;
    hold_pres = bus.stall_i & ~bus.flush_i;

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase

    if (bus.flush_i) begin
      pc_d = {bus.new_pc_i[31:2], 2'b00};
    end else if (bus.branch_i) begin
      pc_d = {bus.branch_target_i[31:2], 2'b00};
    end else if (fetch_ce) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end

    // A stall freezes the presented slot; otherwise it takes whatever was issued now.
    if (hold_pres) begin
      valid_d = valid_q;
      if_pc_d = if_pc_q;
    end else begin
      valid_d = fetch_ce;
      if_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      if_pc_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      if_pc_q <= if_pc_d;
    end
  end

`ifdef FETCH_SKID_EN
  logic [31:0] skid_q, skid_d;
  logic        skid_full_q, skid_full_d;

  always_comb begin
    if (hold_pres && !skid_full_q) begin
      skid_d      = bus.rom_inst_i;
      skid_full_d = 1'b1;
    end else if (hold_pres) begin
      skid_d      = skid_q;
      skid_full_d = 1'b1;
    end else begin
      skid_d      = skid_q;
      skid_full_d = 1'b0;
    end
    inst_src = skid_full_q ? skid_q : bus.rom_inst_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q      <= 32'h0000_0000;
      skid_full_q <= 1'b0;
    end else begin
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
    end
  end
`else
  always_comb begin
    inst_src = bus.rom_inst_i;
  end
`endif

  // Gating by valid_q keeps the word at zero through reset and after a flush.
  always_comb begin
    bus.rom_ce_o   = fetch_ce;
    bus.rom_addr_o = pc_q;
    bus.if_valid_o = valid_q;
    bus.if_pc_o    = if_pc_q;
    bus.if_inst_o  = valid_q ? inst_src : 32'h0000_0000;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: issued fetches are queued from a reference
// PC model and compared when the fetch stage presents them.
module tb_inst_fetch;

  logic clk;
  logic rst;
  inst_fetch_if bus ();

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic        exp_run;
  logic        exp_ce;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Registered ROM that holds its output while not enabled.
  always @(posedge clk) begin
    if (bus.rom_ce_o) bus.rom_inst_i <= rom_word(bus.rom_addr_o);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ce"},    {31'd0, bus.rom_ce_o},   32'd0);
    check({tag, "_addr"},  bus.rom_addr_o,          32'h0000_0000);
    check({tag, "_valid"}, {31'd0, bus.if_valid_o}, 32'd0);
    check({tag, "_pc"},    bus.if_pc_o,             32'd0);
    check({tag, "_inst"},  bus.if_inst_o,           32'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_pc  = 32'h0000_0000;
    exp_run = 1'b0;
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic step(input logic st, input logic br, input logic [31:0] tgt,
                      input logic fl, input logic [31:0] npc);
    bus.stall_i         = st;
    bus.branch_i        = br;
    bus.branch_target_i = tgt;
    bus.flush_i         = fl;
    bus.new_pc_i        = npc;
    #1;
    check("valid", {31'd0, bus.if_valid_o}, {31'd0, (exp_q.size() != 0)});
    if (exp_q.size() != 0) begin
      check("if_pc", bus.if_pc_o, exp_q[0]);
      check("if_inst", bus.if_inst_o, rom_word(exp_q[0]));
      if (!st || fl) void'(exp_q.pop_front());
    end
    exp_ce = exp_run & ~st & ~fl;
    check("rom_ce", {31'd0, bus.rom_ce_o}, {31'd0, exp_ce});
    check("rom_addr", bus.rom_addr_o, exp_pc);
    if (exp_ce) exp_q.push_back(exp_pc);
    if (fl)          exp_pc = npc & 32'hFFFF_FFFC;
    else if (br)     exp_pc = tgt & 32'hFFFF_FFFC;
    else if (exp_ce) exp_pc = exp_pc + 32'd4;
    exp_run = 1'b1;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    rst                 = 1'b1;
    bus.stall_i         = 1'b0;
    bus.branch_i        = 1'b0;
    bus.branch_target_i = 32'd0;
    bus.flush_i         = 1'b0;
    bus.new_pc_i        = 32'd0;
    bus.rom_inst_i      = 32'hDEAD_BEEF;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Boot cycle, then addresses 0..0x10 issued; 0x10 is presented while stalled.
    run(6);
    repeat (3) step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    run(3);
    check("pre_branch_addr", bus.rom_addr_o, 32'h0000_0020);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'd0);
    run(2);
    check("post_branch_addr", bus.rom_addr_o, 32'h0000_0108);

    // Flush during a stall, then flush and branch together.
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'h0000_0180);
    run(2);
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0181);
    check("flush_wins_addr", bus.rom_addr_o, 32'h0000_0180);
    run(2);

    // Address wrap at the top of the space, with unaligned redirect bits.
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFB);
    run(4);

    // Randomised traffic with unaligned targets.
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), $urandom(),
           ($urandom_range(0, 9) == 0), $urandom());
    end

    // Reset pulse in the middle of a stall with a valid instruction presented.
    run(3);
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    bus.stall_i = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_pulse");
    @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    model_reset();
    run(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
